// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the two-port line-memory arbiter.
// State encodings and the tie-break rule live here so the picker and top agree.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 29;
    localparam int LINE_W_DEF = 128;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    // Lone requester wins; on a tie either port 0 (fixed) or the port not served last.
    function automatic logic pick_port(input logic [1:0] valid,
                                       input logic       last_grant,
                                       input logic       fixed_prio);
        logic grant;
        case (valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = fixed_prio ? 1'b0 : ~last_grant;
            default: grant = 1'b0;
        endcase
        return grant;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_pick2.sv
// Combinational two-way grant picker, zero latency.
// Pure function of the request vector and the previous winner; no state.
module arb_pick2
    import mem_port_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       any
);

    always_comb begin
        any   = |valid;
        grant = pick_port(valid, last_grant, FIXED_PRIO);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one line-memory port between I-cache (port 0) and D-cache (port 1).
// Registered outputs: m_valid 1 cycle after grant, sN_ready 1 cycle after m_ready; non-preemptive.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LINE_W     = LINE_W_DEF,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic              s0_wmask,
    input  logic [LINE_W-1:0] s0_wdata,
    output logic [LINE_W-1:0] s0_rdata,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic              s1_wmask,
    input  logic [LINE_W-1:0] s1_wdata,
    output logic [LINE_W-1:0] s1_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_wmask,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata
);

    arb_state_t        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              pick, req_any;

    logic              m_valid_d;
    logic [ADDR_W-1:0] m_addr_d;
    logic              m_wmask_d;
    logic [LINE_W-1:0] m_wdata_d;
    logic              s0_ready_d, s1_ready_d;
    logic [LINE_W-1:0] s0_rdata_d, s1_rdata_d;

    arb_pick2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .valid      ({s1_valid, s0_valid}),
        .last_grant (last_q),
        .grant      (pick),
        .any        (req_any)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        m_valid_d  = m_valid;
        m_addr_d   = m_addr;
        m_wmask_d  = m_wmask;
        m_wdata_d  = m_wdata;
        s0_ready_d = 1'b0;
        s1_ready_d = 1'b0;
        s0_rdata_d = s0_rdata;
        s1_rdata_d = s1_rdata;

        case (state_q)
            ARB_IDLE: begin
                if (req_any) begin
                    gnt_d     = pick;
                    last_d    = pick;
                    m_valid_d = 1'b1;
                    m_addr_d  = pick ? s1_addr  : s0_addr;
                    m_wmask_d = pick ? s1_wmask : s0_wmask;
                    m_wdata_d = pick ? s1_wdata : s0_wdata;
                    state_d   = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (m_valid && m_ready) begin
                    m_valid_d = 1'b0;
                    // Write completions leave the requester's last fill data in place.
                    if (!m_wmask) begin
                        if (gnt_q) s1_rdata_d = m_rdata;
                        else       s0_rdata_d = m_rdata;
                    end
                    if (gnt_q) s1_ready_d = 1'b1;
                    else       s0_ready_d = 1'b1;
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            m_valid  <= 1'b0;
            m_addr   <= '0;
            m_wmask  <= 1'b0;
            m_wdata  <= '0;
            s0_ready <= 1'b0;
            s1_ready <= 1'b0;
            s0_rdata <= '0;
            s1_rdata <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            m_valid  <= m_valid_d;
            m_addr   <= m_addr_d;
            m_wmask  <= m_wmask_d;
            m_wdata  <= m_wdata_d;
            s0_ready <= s0_ready_d;
            s1_ready <= s1_ready_d;
            s0_rdata <= s0_rdata_d;
            s1_rdata <= s1_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: round-robin instance plus a fixed-priority instance.
// A behavioural line memory answers downstream requests with random latency.
module tb_mem_port_arbiter;

    localparam int AW = 29;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s0_valid, s1_valid, s0_wmask, s1_wmask;
    logic [AW-1:0] s0_addr, s1_addr;
    logic [LW-1:0] s0_wdata, s1_wdata;
    logic          m_ready;
    logic [LW-1:0] m_rdata;

    logic          s0_ready, s1_ready, m_valid, m_wmask;
    logic [LW-1:0] s0_rdata, s1_rdata, m_wdata;
    logic [AW-1:0] m_addr;

    logic          fp_s0_valid, fp_s1_valid;
    logic          fp_s0_ready, fp_s1_ready, fp_m_valid, fp_m_wmask;
    logic [LW-1:0] fp_s0_rdata, fp_s1_rdata, fp_m_wdata;
    logic [AW-1:0] fp_m_addr;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_mode = 0;
    int mem_lat  = 0;
    int wait_cnt = 0;

    logic [LW-1:0] mem_store [logic [AW-1:0]];
    logic [LW-1:0] exp_mem   [logic [AW-1:0]];
    logic [LW-1:0] exp_rdata [2];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr),
        .s0_wmask(s0_wmask), .s0_wdata(s0_wdata), .s0_rdata(s0_rdata),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr),
        .s1_wmask(s1_wmask), .s1_wdata(s1_wdata), .s1_rdata(s1_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
        .m_wmask(m_wmask), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(fp_s0_valid), .s0_ready(fp_s0_ready), .s0_addr(s0_addr),
        .s0_wmask(s0_wmask), .s0_wdata(s0_wdata), .s0_rdata(fp_s0_rdata),
        .s1_valid(fp_s1_valid), .s1_ready(fp_s1_ready), .s1_addr(s1_addr),
        .s1_wmask(s1_wmask), .s1_wdata(s1_wdata), .s1_rdata(fp_s1_rdata),
        .m_valid(fp_m_valid), .m_ready(m_ready), .m_addr(fp_m_addr),
        .m_wmask(fp_m_wmask), .m_wdata(fp_m_wdata), .m_rdata(m_rdata)
    );

    function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
        return {4{3'b101, a}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line memory: answers the round-robin instance after 0..3 wait cycles.
    initial begin
        m_ready = 1'b0;
        m_rdata = '0;
        forever begin
            step();
            if (mem_mode == 1) begin
                if (m_ready) begin
                    m_ready = 1'b0;
                end else if (m_valid) begin
                    if (wait_cnt >= mem_lat) begin
                        m_ready = 1'b1;
                        if (m_wmask) begin
                            mem_store[m_addr] = m_wdata;
                            m_rdata = {$urandom, $urandom, $urandom, $urandom};
                        end else begin
                            m_rdata = mem_store.exists(m_addr) ? mem_store[m_addr] : init_line(m_addr);
                        end
                        wait_cnt = 0;
                        mem_lat  = int'($urandom_range(0, 3));
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        s0_valid = 1'b0; s1_valid = 1'b0; fp_s0_valid = 1'b0; fp_s1_valid = 1'b0;
        s0_wmask = 1'b0; s1_wmask = 1'b0;
        s0_addr = '0; s1_addr = '0; s0_wdata = '0; s1_wdata = '0;
        mem_mode = 0; m_ready = 1'b0; wait_cnt = 0;
        mem_store.delete();
        exp_mem.delete();
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic do_txn(input int p, input logic [AW-1:0] a, input logic w,
                          input logic [LW-1:0] d, output logic [LW-1:0] rd,
                          output logic [AW-1:0] ma, output logic mw, output logic [LW-1:0] md);
        bit done;
        done = 0;
        rd = '0; ma = '0; mw = 1'b0; md = '0;
        if (p == 0) begin s0_addr = a; s0_wmask = w; s0_wdata = d; s0_valid = 1'b1; end
        else        begin s1_addr = a; s1_wmask = w; s1_wdata = d; s1_valid = 1'b1; end
        for (int c = 0; c < 200 && !done; c++) begin
            step();
            if (m_valid) begin ma = m_addr; mw = m_wmask; md = m_wdata; end
            if (p == 0 ? s0_ready : s1_ready) begin
                rd = (p == 0) ? s0_rdata : s1_rdata;
                done = 1;
            end
        end
        if (p == 0) s0_valid = 1'b0; else s1_valid = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL txn_timeout port=%0d: ready not seen, required within 200 cycles", p);
        end
    endtask

    task automatic tie_round(input int exp_first, input string tag);
        int order[$];
        s0_addr = 29'h0000100; s1_addr = 29'h0000200;
        s0_wmask = 1'b0; s1_wmask = 1'b0;
        s0_valid = 1'b1; s1_valid = 1'b1;
        for (int c = 0; c < 100 && order.size() < 2; c++) begin
            step();
            if (s0_ready) begin order.push_back(0); s0_valid = 1'b0; end
            if (s1_ready) begin order.push_back(1); s1_valid = 1'b0; end
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        n_checks++;
        if (order.size() != 2 || order[0] != exp_first || order[1] != 1 - exp_first) begin
            n_fail++;
            $display("FAIL %s: served count=%0d first=%0d, required first=%0d then %0d",
                     tag, order.size(), (order.size() > 0) ? order[0] : -1, exp_first, 1 - exp_first);
        end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        s0_valid = 1'b0; s1_valid = 1'b0; fp_s0_valid = 1'b0; fp_s1_valid = 1'b0;
        s0_wmask = 1'b0; s1_wmask = 1'b0; m_ready = 1'b0;
        s0_addr = '0; s1_addr = '0; s0_wdata = '0; s1_wdata = '0;
        step();
        step();
        n_checks++;
        if ({m_valid, s0_ready, s1_ready, m_wmask} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: m_valid/s0_ready/s1_ready/m_wmask=%b, required 0000",
                     {m_valid, s0_ready, s1_ready, m_wmask});
        end
        n_checks++;
        if (m_addr !== '0 || m_wdata !== '0 || s0_rdata !== '0 || s1_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_data: m_addr=%h m_wdata=%h s0_rdata=%h s1_rdata=%h, required 0",
                     m_addr, m_wdata, s0_rdata, s1_rdata);
        end
        n_checks++;
        if ({fp_m_valid, fp_s0_ready, fp_s1_ready} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_fp: outputs=%b, required 000", {fp_m_valid, fp_s0_ready, fp_s1_ready});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        logic [LW-1:0] line;
        line = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        do_reset();
        s0_addr = 29'h0001230; s0_wmask = 1'b0; s0_valid = 1'b1;
        step();
        n_checks++;
        if (m_valid !== 1'b1 || m_addr !== 29'h0001230 || m_wmask !== 1'b0) begin
            n_fail++;
            $display("FAIL read_issue: m_valid=%b m_addr=%h m_wmask=%b, required 1 0001230 0",
                     m_valid, m_addr, m_wmask);
        end
        s0_addr = 29'h1FFFFFF0;
        step();
        step();
        n_checks++;
        if (m_valid !== 1'b1 || m_addr !== 29'h0001230 || s0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL read_hold: m_valid=%b m_addr=%h s0_ready=%b, required 1 0001230 0",
                     m_valid, m_addr, s0_ready);
        end
        m_ready = 1'b1;
        m_rdata = line;
        step();
        n_checks++;
        if (s0_ready !== 1'b1 || s1_ready !== 1'b0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_done: s0_ready=%b s1_ready=%b m_valid=%b, required 1 0 0",
                     s0_ready, s1_ready, m_valid);
        end
        n_checks++;
        if (s0_rdata !== line) begin
            n_fail++;
            $display("FAIL read_data: s0_rdata=%h, required %h", s0_rdata, line);
        end
        m_ready = 1'b0;
        m_rdata = '0;
        s0_valid = 1'b0;
        step();
        n_checks++;
        if (s0_ready !== 1'b0 || s0_rdata !== line) begin
            n_fail++;
            $display("FAIL read_pulse: s0_ready=%b s0_rdata=%h, required 0 %h", s0_ready, s0_rdata, line);
        end
    endtask

    task automatic test_round_robin();
        int model_last;
        int exp_first;
        logic [LW-1:0] rd, md;
        logic [AW-1:0] ma;
        logic mw;
        do_reset();
        mem_mode = 1;
        model_last = 1;
        for (int r = 0; r < 4; r++) begin
            exp_first = (model_last == 0) ? 1 : 0;
            tie_round(exp_first, "rr_tie");
            model_last = 1 - exp_first;
        end
        do_txn(0, 29'h0000300, 1'b0, '0, rd, ma, mw, md);
        model_last = 0;
        step();
        exp_first = (model_last == 0) ? 1 : 0;
        tie_round(exp_first, "rr_after_p0");
        model_last = 1 - exp_first;
        exp_first = (model_last == 0) ? 1 : 0;
        tie_round(exp_first, "rr_repeat");
    endtask

    task automatic test_fixed_prio();
        int c0, c1, spur;
        logic [LW-1:0] line;
        do_reset();
        line = {$urandom, $urandom, $urandom, $urandom};
        m_ready = 1'b1;
        m_rdata = line;
        s0_addr = 29'h0000500; s1_addr = 29'h0000600;
        fp_s0_valid = 1'b1;
        fp_s1_valid = 1'b1;
        c0 = 0; c1 = 0; spur = 0;
        repeat (30) begin
            step();
            if (fp_s0_ready) begin
                c0++;
                n_checks++;
                if (fp_s0_rdata !== line) begin
                    n_fail++;
                    $display("FAIL fp_rdata: fp_s0_rdata=%h, required %h", fp_s0_rdata, line);
                end
            end
            if (fp_s1_ready) c1++;
            if (s0_ready || s1_ready || m_valid) spur++;
        end
        n_checks++;
        if (c0 != 10 || c1 != 0) begin
            n_fail++;
            $display("FAIL fp_both_held: port0 grants=%0d port1 grants=%0d, required 10 and 0", c0, c1);
        end
        n_checks++;
        if (spur != 0) begin
            n_fail++;
            $display("FAIL spurious_idle: idle instance reacted %0d cycles, required 0", spur);
        end
        fp_s0_valid = 1'b0;
        c1 = 0;
        repeat (10) begin
            step();
            if (fp_s1_ready) c1++;
        end
        n_checks++;
        if (c1 != 3) begin
            n_fail++;
            $display("FAIL fp_port1_alone: port1 grants=%0d, required 3", c1);
        end
        fp_s1_valid = 1'b0;
        m_ready = 1'b0;
        step();
    endtask

    task automatic test_write_fill();
        logic [LW-1:0] pat, rd, md;
        logic [AW-1:0] ma;
        logic mw;
        pat = {16{8'hA5}};
        do_reset();
        mem_mode = 1;
        do_txn(1, 29'h0000400, 1'b1, pat, rd, ma, mw, md);
        n_checks++;
        if (mw !== 1'b1 || md !== pat || ma !== 29'h0000400) begin
            n_fail++;
            $display("FAIL wb_fwd: m_wmask=%b m_wdata=%h m_addr=%h, required 1 %h 0000400", mw, md, ma, pat);
        end
        n_checks++;
        if (rd !== '0) begin
            n_fail++;
            $display("FAIL wb_rdata: s1_rdata=%h after write, required unchanged 0", rd);
        end
        step();
        do_txn(1, 29'h0000400, 1'b0, '0, rd, ma, mw, md);
        n_checks++;
        if (mw !== 1'b0 || rd !== pat) begin
            n_fail++;
            $display("FAIL fill_after_wb: m_wmask=%b s1_rdata=%h, required 0 %h", mw, rd, pat);
        end
        n_checks++;
        if (s0_rdata !== '0) begin
            n_fail++;
            $display("FAIL fill_isolation: s0_rdata=%h, required 0", s0_rdata);
        end
        mem_mode = 0;
        step();
    endtask

    task automatic test_reset_in_req();
        do_reset();
        s0_addr = 29'h0000700; s0_wmask = 1'b0; s0_valid = 1'b1;
        step();
        n_checks++;
        if (m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_req_setup: m_valid=%b, required 1", m_valid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({m_valid, s0_ready, s1_ready} !== 3'b0) begin
            n_fail++;
            $display("FAIL rst_in_req: m_valid/s0_ready/s1_ready=%b, required 000", {m_valid, s0_ready, s1_ready});
        end
        s0_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_release: m_valid=%b, required 0", m_valid);
        end
        mem_mode = 1;
        tie_round(0, "rst_first_tie");
        mem_mode = 0;
    endtask

    task automatic test_spurious_ready();
        int bad;
        do_reset();
        m_ready = 1'b1;
        bad = 0;
        repeat (3) begin
            step();
            if (s0_ready || s1_ready || m_valid) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL spur_idle: %0d cycles with activity, required 0", bad);
        end
        s0_addr = 29'h0000800; s0_wmask = 1'b0; s0_valid = 1'b1;
        step();
        n_checks++;
        if (m_valid !== 1'b1 || s0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL spur_grant: m_valid=%b s0_ready=%b, required 1 0", m_valid, s0_ready);
        end
        step();
        n_checks++;
        if (s0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL spur_complete: s0_ready=%b, required 1", s0_ready);
        end
        s0_valid = 1'b0;
        step();
        n_checks++;
        if ({m_valid, s0_ready, s1_ready} !== 3'b0) begin
            n_fail++;
            $display("FAIL spur_resp: m_valid/s0_ready/s1_ready=%b, required 000", {m_valid, s0_ready, s1_ready});
        end
        step();
        n_checks++;
        if ({m_valid, s0_ready, s1_ready} !== 3'b0) begin
            n_fail++;
            $display("FAIL spur_after: m_valid/s0_ready/s1_ready=%b, required 000", {m_valid, s0_ready, s1_ready});
        end
        m_ready = 1'b0;
    endtask

    // Each port works on its own address range so per-port ordering fixes the expected data.
    task automatic requester(input int p, input int n);
        logic [AW-1:0] a, ma;
        logic          w, mw;
        logic [LW-1:0] d, rd, md, exp;
        for (int k = 0; k < n; k++) begin
            a = AW'((p + 1) * 4096 + 16 * int'($urandom_range(0, 7)));
            w = 1'($urandom_range(0, 1));
            d = {$urandom, $urandom, $urandom, $urandom};
            exp = w ? exp_rdata[p] : (exp_mem.exists(a) ? exp_mem[a] : init_line(a));
            if (w) exp_mem[a] = d;
            else   exp_rdata[p] = exp;
            repeat ($urandom_range(0, 3)) step();
            do_txn(p, a, w, d, rd, ma, mw, md);
            n_checks++;
            if (rd !== exp) begin
                n_fail++;
                $display("FAIL rand_data port=%0d txn=%0d wr=%b: rdata=%h, required %h", p, k, w, rd, exp);
            end
        end
    endtask

    task automatic test_random();
        bit rand_done;
        rand_done = 0;
        do_reset();
        mem_mode = 1;
        fork
            begin
                fork
                    requester(0, 30);
                    requester(1, 30);
                join
                rand_done = 1;
            end
            begin : mon
                logic          pv, pr;
                logic [AW-1:0] pa;
                pv = 1'b0; pr = 1'b0; pa = '0;
                while (!rand_done) begin
                    step();
                    n_checks++;
                    if (s0_ready && s1_ready) begin
                        n_fail++;
                        $display("FAIL both_ready: s0_ready=%b s1_ready=%b, required not both", s0_ready, s1_ready);
                    end
                    if (pv && m_valid && !pr) begin
                        n_checks++;
                        if (m_addr !== pa) begin
                            n_fail++;
                            $display("FAIL m_stable: m_addr=%h, required held %h", m_addr, pa);
                        end
                    end
                    pv = m_valid; pa = m_addr; pr = m_ready;
                end
            end
        join
        mem_mode = 0;
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_prio();
        test_write_fill();
        test_reset_in_req();
        test_spurious_ready();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
